// File: rtl/alu_sequencer.sv
// Purpose : instruction fetch/decode sequencer that drives the ALU operand bus for an 8-bit CPU.
// Latency : ALU op is 3 + ALU_LAT cycles (FETCH, DECODE, EXEC x ALU_LAT, WB) with zero-wait memory.
// Backpressure: FETCH/IMM hold mem_req/mem_addr until mem_ack; nothing else stalls.
//
// Ports
//   clk, rst             : single clock, synchronous active-high reset
//   run                  : start / resume pulse, honoured only in IDLE and HALT
//   mem_req/mem_addr     : program-memory read request, address = pc while requesting
//   mem_ack/mem_rdata    : memory reply, data valid in the ack cycle
//   alu_inst/alu_ra/rb   : registered ALU inputs, loaded on DECODE of an ALU op and held afterwards
//   alu_rd/alu_flags     : ALU result, sampled in WB (ALU_LAT cycles after the inputs settle)
//   flags, pc            : architectural flags and program counter
//   busy, halted         : status (busy outside IDLE/HALT, halted in HALT)
//   dbg_sel/dbg_data     : combinational register-file read port
module alu_sequencer #(
   parameter int unsigned ALU_LAT  = 2,
   parameter logic [7:0]  RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   output logic       mem_req,
   output logic [7:0] mem_addr,
   input  logic       mem_ack,
   input  logic [7:0] mem_rdata,
   output logic [7:0] alu_inst,
   output logic [7:0] alu_ra,
   output logic [7:0] alu_rb,
   input  logic [7:0] alu_rd,
   input  logic [7:0] alu_flags,
   output logic [7:0] flags,
   output logic [7:0] pc,
   output logic       busy,
   output logic       halted,
   input  logic [1:0] dbg_sel,
   output logic [7:0] dbg_data
);

   // Instruction byte layout: opcode, a (destination and source A), b (source B).
   typedef struct packed {
      logic [3:0] opcode;
      logic [1:0] a;
      logic [1:0] b;
   } inst_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Wide enough to hold ALU_LAT itself; at least one bit for ALU_LAT == 1.
   localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_IMM,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   inst_t            ir;
   logic [7:0]       regs [4];
   logic [CNT_W-1:0] exec_cnt;

   // Per-cycle control strobes produced by the next-state logic.
   logic ir_ld;     // capture fetched opcode byte
   logic pc_inc;    // advance pc after any accepted fetch
   logic imm_we;    // write immediate byte into R[a]
   logic alu_ld;    // launch an ALU op: load operand registers and latency counter
   logic wb_we;     // write ALU result into R[a] and capture flags

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      ir_ld     = 1'b0;
      pc_inc    = 1'b0;
      imm_we    = 1'b0;
      alu_ld    = 1'b0;
      wb_we     = 1'b0;

      case (state)
         S_IDLE: begin
            if (run) state_nxt = S_FETCH;
         end

         S_FETCH: begin
            if (mem_ack) begin
               ir_ld     = 1'b1;
               pc_inc    = 1'b1;
               state_nxt = S_DECODE;
            end
         end

         S_DECODE: begin
            case (ir.opcode)
               OP_NOP:  state_nxt = S_FETCH;
               OP_LDI:  state_nxt = S_IMM;
               OP_HALT: state_nxt = S_HALT;
               default: begin
                  alu_ld    = 1'b1;
                  state_nxt = S_EXEC;
               end
            endcase
         end

         S_IMM: begin
            if (mem_ack) begin
               imm_we    = 1'b1;
               pc_inc    = 1'b1;
               state_nxt = S_FETCH;
            end
         end

         S_EXEC: begin
            // Counter was loaded with ALU_LAT, so EXEC lasts exactly ALU_LAT cycles
            // and WB sees the result of the operands launched at DECODE.
            if (exec_cnt == CNT_W'(1)) state_nxt = S_WB;
         end

         S_WB: begin
            wb_we     = 1'b1;
            state_nxt = S_FETCH;
         end

         S_HALT: begin
            if (run) state_nxt = S_FETCH;
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: pc, instruction register, register file, flags, ALU bus
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         ir       <= '0;
         flags    <= '0;
         alu_inst <= '0;
         alu_ra   <= '0;
         alu_rb   <= '0;
         exec_cnt <= '0;
         for (int i = 0; i < 4; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (pc_inc) pc <= pc + 8'd1;   // natural 8-bit wrap 0xFF -> 0x00

         if (ir_ld) ir <= inst_t'(mem_rdata);

         // Operands are registered here, so they stay fixed through EXEC and WB
         // even when a == b and WB rewrites the source register.
         if (alu_ld) begin
            alu_inst <= ir;
            alu_ra   <= regs[ir.a];
            alu_rb   <= regs[ir.b];
            exec_cnt <= CNT_W'(ALU_LAT);
         end else if (state == S_EXEC) begin
            exec_cnt <= exec_cnt - CNT_W'(1);
         end

         // imm_we and wb_we come from different states and never coincide.
         if (imm_we) regs[ir.a] <= mem_rdata;
         if (wb_we) begin
            regs[ir.a] <= alu_rd;
            flags      <= alu_flags;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mem_req  = (state == S_FETCH) || (state == S_IMM);
   assign mem_addr = mem_req ? pc : 8'h00;
   assign busy     = (state != S_IDLE) && (state != S_HALT);
   assign halted   = (state == S_HALT);
   assign dbg_data = regs[dbg_sel];

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Instruction-sequencing controller for the 8-bit CPU. It fetches instruction bytes from program memory over a req/ack handshake and decodes them. It feeds operands from an internal 4x8 register file into ArithmeticLogicUnit, waits the ALU latency, then writes the result and flags back. It sits between program memory and the ALU and is the only driver of ALU inst/ra/rb.

Parameters:
ALU_LAT, 2, clock cycles from stable ALU inputs to valid alu_rd/alu_flags (>=1)
RESET_PC, 8'h00, pc value after reset

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
run  in  1  start/resume pulse, sampled in IDLE and HALT only
mem_req  out  1  fetch request
mem_addr  out  8  fetch address (= pc while mem_req high)
mem_ack  in  1  memory has mem_rdata valid this cycle
mem_rdata  in  8  fetched byte
alu_inst  out  8  instruction byte to ALU
alu_ra  out  8  operand A to ALU
alu_rb  out  8  operand B to ALU
alu_rd  in  8  ALU result
alu_flags  in  8  ALU flags
flags  out  8  architectural flags register
pc  out  8  program counter
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
dbg_sel  in  2  register-file debug read select
dbg_data  out  8  R[dbg_sel], combinational

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on rst. rst is sampled only at the clk edge and overrides every other input.
- Reset: state=IDLE, pc=RESET_PC, R0..R3=0, flags=0, all outputs 0 (dbg_data = 0 because regs are 0).
- Instruction byte: [7:4] opcode, [3:2] a (dest and source A), [1:0] b (source B).
- Opcodes:
  - 0x0 NOP.
  - 0x1 LDI: the next byte is an immediate loaded into R[a].
  - 0xF HALT.
  - All other opcodes are ALU ops forwarded unchanged.
- FSM states: IDLE, FETCH, DECODE, IMM, EXEC, WB, HALT.
- IDLE: wait for run=1, then go to FETCH.
- FETCH:
  - mem_req=1, mem_addr=pc; both held stable until mem_ack.
  - On mem_ack: latch ir=mem_rdata, pc<=pc+1 (mod 256, 0xFF wraps to 0x00), mem_req drops next cycle, go to DECODE.
  - mem_ack outside FETCH/IMM is ignored.
- DECODE (1 cycle):
  - NOP -> FETCH.
  - HALT -> HALT.
  - LDI -> IMM.
  - ALU op: drive alu_inst=ir, alu_ra=R[a], alu_rb=R[b], then go to EXEC with counter=ALU_LAT.
- IMM:
  - Same handshake as FETCH at pc.
  - On mem_ack: R[a]<=mem_rdata, pc<=pc+1, go to FETCH. flags unchanged.
- EXEC:
  - alu_inst/alu_ra/alu_rb held constant.
  - Counter decrements each cycle; at 1 go to WB.
- WB (1 cycle): R[a]<=alu_rd, flags<=alu_flags, go to FETCH.
  - alu_* outputs hold their values until the next DECODE of an ALU op; they are not cleared.
- ALU op latency with zero-wait memory (ack in first FETCH cycle): FETCH 1 + DECODE 1 + EXEC ALU_LAT + WB 1 = 5 cycles at default.
- HALT:
  - halted=1, busy=0, pc points past the HALT byte.
  - run=1 -> FETCH (resume). Otherwise stay.
- run while busy: ignored.
- a==b: operand A and B both read R[a]. Writeback to R[a] occurs only in WB, so operands are unaffected during EXEC.
- Reset mid-fetch: mem_req=0 on the cycle after the reset edge. No register, flags or pc update from that instruction.

Test Plan:
- Reset: hold rst 3 cycles mid-FETCH -> next cycle mem_req=0, pc=0x00, flags=0x00, busy=0, halted=0, dbg_data=0 for all dbg_sel.
- LDI then ALU:
  - Stimulus: mem = {0x10, 0x0B, 0x14, 0x02, 0x51, 0xF0}, zero-wait ack, run pulse.
  - Required: R0=0x0B, R1=0x02.
  - At the 0x51 DECODE: alu_inst=0x51, alu_ra=0x0B, alu_rb=0x02 stable for ALU_LAT+1 cycles.
  - After WB: R0=alu_rd, flags=alu_flags.
  - Then halted=1, pc=0x06.
- Wait states: mem_ack delayed 3 cycles on every fetch -> mem_req/mem_addr stable through the wait; program result identical to the previous scenario.
- PC wrap: RESET_PC=0xFF, mem[0xFF]=0x00 (NOP), mem[0x00]=0xF0 -> halted=1, pc=0x01.
- Resume and run-while-busy:
  - run pulsed during EXEC -> no effect.
  - run pulsed in HALT -> next cycle mem_req=1 with mem_addr=pc; execution continues.
- NOP flags hold: flags=0x80 after an ALU op, then NOP -> flags stays 0x80; no register changes.
